frame_buffer_scheduler: RTL and testbench
=========================================

Name: frame_buffer_scheduler

Overview:
- Owns the single-port grayscale frame-buffer RAM and shares it between two requesters: the VGA output stage (pixel fetch on new_pixel_request) and the convolution engine (read/write).
- Double-buffered. The VGA side reads the front bank. Convolution reads source pixels from the front bank and writes results to the back bank.
- Banks swap at a frame boundary after convolution signals done. VGA has strict priority because its deadline is hard.

Parameters:
- IMG_W, 320, image width in pixels.
- IMG_H, 240, image height in pixels.
- PIX_W, 4, grayscale pixel width.
- ADDR_W, 18, RAM address width; must satisfy 2^ADDR_W >= 2*IMG_W*IMG_H.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- vga_req  in  1  pixel request; one request per cycle at most.
- vga_x  in  10  requested pixel column.
- vga_y  in  10  requested pixel row.
- vga_frame_start  in  1  one-cycle pulse at start of each displayed frame.
- vga_pixel  out  PIX_W  fetched pixel; drives grayscale_pixel.
- vga_pixel_valid  out  1  pulse: vga_pixel is valid this cycle.
- display_image  out  1  high with vga_pixel_valid when the pixel is inside the image.
- conv_req  in  1  convolution access request; hold with fields stable until granted.
- conv_we  in  1  1 = write to back bank, 0 = read from front bank.
- conv_addr  in  ADDR_W-1  image-relative linear address (y*IMG_W+x).
- conv_wdata  in  PIX_W  write data.
- conv_gnt  out  1  combinational grant; the access is accepted on the edge where conv_req && conv_gnt.
- conv_rvalid  out  1  pulse carrying conv_rdata.
- conv_rdata  out  PIX_W  read data.
- conv_frame_done  in  1  pulse: back bank holds a complete result frame.
- swap_pending  out  1  done received, swap not yet applied.
- frame_swapped  out  1  one-cycle pulse when the banks swap.
- front_bank  out  1  current display bank.
- mem_en  out  1  RAM enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_wdata  out  PIX_W  RAM write data (registered).
- mem_rdata  in  PIX_W  RAM read data, valid one cycle after the mem_en edge.

Behaviour:
- Reset (async): all outputs 0, front_bank=0, swap_pending=0, pipeline tags cleared. Reset mid-operation discards in-flight reads; no valid pulses are issued after reset.
- Arbitration per cycle: vga_req wins. conv_gnt = conv_req && !vga_req && !swap_pending. Only one RAM access is issued per cycle.
- VGA slot, in range (vga_x<IMG_W and vga_y<IMG_H):
  - mem_addr = front_bank*IMG_W*IMG_H + vga_y*IMG_W + vga_x, with mem_en=1 and mem_we=0.
  - The product is computed at full width, then truncated to ADDR_W.
- VGA slot, out of range: no RAM access (mem_en=0). The pipeline still produces vga_pixel=0 with display_image=0.
- Latency: a request sampled at edge E0 produces vga_pixel_valid at the output after edge E2, i.e. exactly 2 cycles, fixed. Back-to-back requests yield back-to-back valid pulses.
- Conv read: mem_addr = front_bank*IMG_W*IMG_H + conv_addr. conv_rvalid and conv_rdata follow the grant edge by the same 2 cycles.
- Conv write: mem_addr = (!front_bank)*IMG_W*IMG_H + conv_addr, mem_we=1. No response is returned.
- conv_addr >= IMG_W*IMG_H: the grant is still given, and the access is dropped (mem_en=0). For a read, conv_rvalid still pulses with conv_rdata=0.
- A 2-stage tag pipeline {none, vga, conv, in_range} steers mem_rdata to the correct output.
- Swap FSM, states IDLE and PENDING:
  - IDLE + conv_frame_done → PENDING.
  - PENDING + vga_frame_start → toggle front_bank, pulse frame_swapped, go to IDLE.
  - conv_frame_done and vga_frame_start in the same cycle while in IDLE: swap immediately in that cycle.
  - conv_frame_done while already PENDING: ignored.
  - While PENDING, conv_gnt=0, which stalls the convolution engine until the swap.
  - In-flight reads issued before a swap complete from the old bank.

Optional Feature:
- Macro: STARVE_STAT_EN.
- Defined: adds output conv_max_wait [15:0]. A counter runs while conv_req is high and ungranted, and clears on grant. conv_max_wait holds the largest count seen, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and logic are absent.

Test Plan:
- Reset, preload bank0[5*320+7]=4'hA, vga_req with x=7,y=5 → vga_pixel=4'hA, vga_pixel_valid=1, display_image=1 exactly 2 cycles later; mem_addr=1607.
- vga_req with x=400,y=10 → mem_en stays 0; after 2 cycles valid=1, vga_pixel=0, display_image=0.
- vga_req and conv_req (read, addr 3) asserted together for 1 cycle → VGA served; conv_gnt=0 that cycle, 1 the next; conv_rvalid 2 cycles after grant.
- Conv write addr 10 data 4'h3 with front_bank=0 → mem_addr=76810, mem_we=1. After done plus frame_start: frame_swapped pulses, front_bank=1, and VGA (10,0) returns 4'h3.
- conv_frame_done, then conv_req held 20 cycles before vga_frame_start → conv_gnt=0 throughout and swap_pending=1. The grant is given the cycle after the swap (STARVE_STAT_EN: conv_max_wait ≥20).
- Assert reset with 2 VGA reads in flight → no vga_pixel_valid afterwards; all outputs 0 and front_bank=0.

Source files
------------

// File: rtl/frame_buffer_scheduler_if.sv
// Frame-buffer scheduler bus bundle.
// Groups the VGA fetch port, the convolution access port, the bank-swap
// status and the single-port RAM port into one interface.
//   slave  : seen by frame_buffer_scheduler
//   master : seen by whatever drives the requests and models the RAM
// Optional macro STARVE_STAT_EN adds conv_max_wait[15:0].
interface frame_buffer_scheduler_if #(
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned ADDR_W = 18
);
    // VGA fetch port
    logic              vga_req;
    logic [9:0]        vga_x;
    logic [9:0]        vga_y;
    logic              vga_frame_start;
    logic [PIX_W-1:0]  vga_pixel;
    logic              vga_pixel_valid;
    logic              display_image;
    // Convolution access port
    logic              conv_req;
    logic              conv_we;
    logic [ADDR_W-2:0] conv_addr;
    logic [PIX_W-1:0]  conv_wdata;
    logic              conv_gnt;
    logic              conv_rvalid;
    logic [PIX_W-1:0]  conv_rdata;
    logic              conv_frame_done;
    // Bank swap status
    logic              swap_pending;
    logic              frame_swapped;
    logic              front_bank;
    // RAM port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;
`ifdef STARVE_STAT_EN
    logic [15:0]       conv_max_wait;
`endif

    modport slave (
`ifdef STARVE_STAT_EN
        output conv_max_wait,
`endif
        input  vga_req, vga_x, vga_y, vga_frame_start,
        output vga_pixel, vga_pixel_valid, display_image,
        input  conv_req, conv_we, conv_addr, conv_wdata, conv_frame_done,
        output conv_gnt, conv_rvalid, conv_rdata,
        output swap_pending, frame_swapped, front_bank,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
`ifdef STARVE_STAT_EN
        input  conv_max_wait,
`endif
        output vga_req, vga_x, vga_y, vga_frame_start,
        input  vga_pixel, vga_pixel_valid, display_image,
        output conv_req, conv_we, conv_addr, conv_wdata, conv_frame_done,
        input  conv_gnt, conv_rvalid, conv_rdata,
        input  swap_pending, frame_swapped, front_bank,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Frame-buffer scheduler.
// Shares one single-port grayscale RAM between the VGA output stage and the
// convolution engine, with double buffering: VGA and convolution reads use
// the front bank, convolution writes go to the back bank. Banks swap on a
// VGA frame start once the convolution engine has reported a finished frame.
// VGA always wins arbitration; read data returns exactly 2 cycles after the
// request edge for both requesters.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - frame_buffer_scheduler_if.slave (VGA, conv, swap status, RAM)
// Optional macro STARVE_STAT_EN adds bus.conv_max_wait, the longest number
// of cycles a convolution request has waited for a grant (saturating).
module frame_buffer_scheduler #(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned ADDR_W = 18
) (
    input logic                      clk,
    input logic                      reset,
    frame_buffer_scheduler_if.slave  bus
);
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;

    typedef enum logic { SWAP_IDLE, SWAP_PENDING } swap_state_t;
    typedef enum logic [1:0] { TAG_NONE, TAG_VGA, TAG_CONV } tag_kind_t;
    typedef struct packed {
        tag_kind_t kind;
        logic      in_range;
    } tag_t;

    swap_state_t       state, state_next;
    logic              swap_now;
    logic              front_bank_q, frame_swapped_q;
    logic              conv_gnt;
    logic [31:0]       vga_x32, vga_y32, conv_lin, vga_lin;
    logic [31:0]       front_base, back_base;
    logic              vga_in_range, conv_in_range;
    logic              issue_en, issue_we;
    logic [ADDR_W-1:0] issue_addr;
    tag_t              issue_tag, tag1, tag2;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [PIX_W-1:0]  mem_wdata_q;
    logic              vga_valid_q, display_q, conv_rvalid_q;
    logic [PIX_W-1:0]  vga_pixel_q, conv_rdata_q;

    // A pending swap blocks the convolution engine until the banks flip.
    assign conv_gnt = bus.conv_req && !bus.vga_req && (state != SWAP_PENDING);

    // Address arithmetic is done at 32 bits and truncated only at the RAM.
    always_comb begin
        vga_x32       = 32'(bus.vga_x);
        vga_y32       = 32'(bus.vga_y);
        conv_lin      = 32'(bus.conv_addr);
        vga_lin       = vga_y32 * IMG_W + vga_x32;
        front_base    = front_bank_q ? FRAME_PIX : 32'd0;
        back_base     = front_bank_q ? 32'd0 : FRAME_PIX;
        vga_in_range  = (vga_x32 < IMG_W) && (vga_y32 < IMG_H);
        conv_in_range = conv_lin < FRAME_PIX;
    end

    // Per-cycle slot selection. Out-of-range accesses still carry a tag so
    // the requester sees a (zero) response, but never touch the RAM.
    always_comb begin
        issue_en   = 1'b0;
        issue_we   = 1'b0;
        issue_addr = '0;
        issue_tag  = '{kind: TAG_NONE, in_range: 1'b0};
        if (bus.vga_req) begin
            issue_tag  = '{kind: TAG_VGA, in_range: vga_in_range};
            issue_en   = vga_in_range;
            issue_addr = ADDR_W'(front_base + vga_lin);
        end else if (conv_gnt) begin
            if (bus.conv_we) begin
                issue_en   = conv_in_range;
                issue_we   = conv_in_range;
                issue_addr = ADDR_W'(back_base + conv_lin);
            end else begin
                issue_tag  = '{kind: TAG_CONV, in_range: conv_in_range};
                issue_en   = conv_in_range;
                issue_addr = ADDR_W'(front_base + conv_lin);
            end
        end
    end

    // RAM command register and the 2-stage tag pipeline that follows the
    // RAM's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1        <= '{kind: TAG_NONE, in_range: 1'b0};
            tag2        <= '{kind: TAG_NONE, in_range: 1'b0};
        end else begin
            mem_en_q <= issue_en;
            mem_we_q <= issue_we;
            if (issue_en) begin
                mem_addr_q  <= issue_addr;
                mem_wdata_q <= bus.conv_wdata;
            end
            tag1 <= issue_tag;
            tag2 <= tag1;
        end
    end

    // Steer returning RAM data to whichever requester owns the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_valid_q   <= 1'b0;
            display_q     <= 1'b0;
            vga_pixel_q   <= '0;
            conv_rvalid_q <= 1'b0;
            conv_rdata_q  <= '0;
        end else begin
            vga_valid_q   <= (tag2.kind == TAG_VGA);
            display_q     <= (tag2.kind == TAG_VGA) && tag2.in_range;
            vga_pixel_q   <= ((tag2.kind == TAG_VGA) && tag2.in_range)
                             ? bus.mem_rdata : '0;
            conv_rvalid_q <= (tag2.kind == TAG_CONV);
            conv_rdata_q  <= ((tag2.kind == TAG_CONV) && tag2.in_range)
                             ? bus.mem_rdata : '0;
        end
    end

    // Swap FSM state register and bank select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= SWAP_IDLE;
            front_bank_q    <= 1'b0;
            frame_swapped_q <= 1'b0;
        end else begin
            state           <= state_next;
            front_bank_q    <= front_bank_q ^ swap_now;
            frame_swapped_q <= swap_now;
        end
    end

    // Done and frame start together in IDLE swap at once; a second done
    // while PENDING changes nothing.
    always_comb begin
        state_next = state;
        swap_now   = 1'b0;
        case (state)
            SWAP_IDLE: begin
                if (bus.conv_frame_done && bus.vga_frame_start) begin
                    swap_now = 1'b1;
                end else if (bus.conv_frame_done) begin
                    state_next = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (bus.vga_frame_start) begin
                    swap_now   = 1'b1;
                    state_next = SWAP_IDLE;
                end
            end
            default: state_next = SWAP_IDLE;
        endcase
    end

`ifdef STARVE_STAT_EN
    logic [15:0] wait_cnt, wait_next, max_wait;

    always_comb begin
        wait_next = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
    end

    // Wait counter runs while a conv request is refused; the maximum sticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            max_wait <= '0;
        end else if (bus.conv_req && !conv_gnt) begin
            wait_cnt <= wait_next;
            if (wait_next > max_wait) max_wait <= wait_next;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign bus.conv_max_wait = max_wait;
`endif

    assign bus.conv_gnt        = conv_gnt;
    assign bus.swap_pending    = (state == SWAP_PENDING);
    assign bus.frame_swapped   = frame_swapped_q;
    assign bus.front_bank      = front_bank_q;
    assign bus.mem_en          = mem_en_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.vga_pixel       = vga_pixel_q;
    assign bus.vga_pixel_valid = vga_valid_q;
    assign bus.display_image   = display_q;
    assign bus.conv_rvalid     = conv_rvalid_q;
    assign bus.conv_rdata      = conv_rdata_q;
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed testbench for frame_buffer_scheduler.
// Models the single-port RAM (1-cycle read latency), drives inputs on the
// falling edge and samples outputs on the falling edge.
module tb_frame_buffer_scheduler;
    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    logic [3:0] ram [0:(1<<18)-1];

    frame_buffer_scheduler_if #(.PIX_W(4), .ADDR_W(18)) bus ();

    frame_buffer_scheduler #(
        .IMG_W(320), .IMG_H(240), .PIX_W(4), .ADDR_W(18)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous read, data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.vga_req         = 1'b0;
        bus.vga_x           = '0;
        bus.vga_y           = '0;
        bus.vga_frame_start = 1'b0;
        bus.conv_req        = 1'b0;
        bus.conv_we         = 1'b0;
        bus.conv_addr       = '0;
        bus.conv_wdata      = '0;
        bus.conv_frame_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.mem_rdata = '0;
        step();
        step();
        vectors++;
        if ({bus.vga_pixel, bus.vga_pixel_valid, bus.display_image, bus.conv_rvalid,
             bus.conv_rdata, bus.swap_pending, bus.frame_swapped, bus.mem_en,
             bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.conv_gnt} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: some output nonzero, expected all 0");
        end
        vectors++;
        if (bus.front_bank !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_front_bank: got %b want 0", bus.front_bank);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_vga_in_range();
        ram[1607] = 4'hA;
        bus.vga_req = 1'b1; bus.vga_x = 10'd7; bus.vga_y = 10'd5;
        step();
        bus.vga_req = 1'b0;
        vectors++;
        if (bus.mem_addr !== 18'd1607 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vga_addr: got en=%b we=%b addr=%0d want en=1 we=0 addr=1607",
                     bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vga_early_valid: got %b want 0", bus.vga_pixel_valid);
        end
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b1 || bus.vga_pixel !== 4'hA || bus.display_image !== 1'b1) begin
            errors++;
            $display("[TB] FAIL vga_read: got valid=%b pix=%h disp=%b want 1 a 1",
                     bus.vga_pixel_valid, bus.vga_pixel, bus.display_image);
        end
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vga_valid_pulse: got %b want 0", bus.vga_pixel_valid);
        end
    endtask

    task automatic test_vga_out_of_range();
        bus.vga_req = 1'b1; bus.vga_x = 10'd400; bus.vga_y = 10'd10;
        step();
        bus.vga_req = 1'b0;
        vectors++;
        if (bus.mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vga_oor_mem_en: got %b want 0", bus.mem_en);
        end
        step();
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b1 || bus.vga_pixel !== 4'h0 || bus.display_image !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vga_oor_resp: got valid=%b pix=%h disp=%b want 1 0 0",
                     bus.vga_pixel_valid, bus.vga_pixel, bus.display_image);
        end
        step();
    endtask

    task automatic test_arbitration();
        ram[0] = 4'h1;
        ram[3] = 4'h5;
        bus.vga_req = 1'b1; bus.vga_x = 10'd0; bus.vga_y = 10'd0;
        bus.conv_req = 1'b1; bus.conv_we = 1'b0; bus.conv_addr = 17'd3;
        #1;
        vectors++;
        if (bus.conv_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arb_gnt_blocked: got %b want 0", bus.conv_gnt);
        end
        step();
        bus.vga_req = 1'b0;
        #1;
        vectors++;
        if (bus.conv_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arb_gnt_next: got %b want 1", bus.conv_gnt);
        end
        step();
        bus.conv_req = 1'b0;
        vectors++;
        if (bus.mem_addr !== 18'd3) begin
            errors++;
            $display("[TB] FAIL arb_conv_addr: got %0d want 3", bus.mem_addr);
        end
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b1 || bus.vga_pixel !== 4'h1 || bus.conv_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arb_vga_first: got valid=%b pix=%h rvalid=%b want 1 1 0",
                     bus.vga_pixel_valid, bus.vga_pixel, bus.conv_rvalid);
        end
        step();
        vectors++;
        if (bus.conv_rvalid !== 1'b1 || bus.conv_rdata !== 4'h5) begin
            errors++;
            $display("[TB] FAIL arb_conv_read: got rvalid=%b data=%h want 1 5",
                     bus.conv_rvalid, bus.conv_rdata);
        end
        step();
    endtask

    task automatic test_conv_out_of_range();
        bus.conv_req = 1'b1; bus.conv_we = 1'b0; bus.conv_addr = 17'd76800;
        #1;
        vectors++;
        if (bus.conv_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conv_oor_gnt: got %b want 1", bus.conv_gnt);
        end
        step();
        bus.conv_req = 1'b0;
        vectors++;
        if (bus.mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conv_oor_mem_en: got %b want 0", bus.mem_en);
        end
        step();
        step();
        vectors++;
        if (bus.conv_rvalid !== 1'b1 || bus.conv_rdata !== 4'h0) begin
            errors++;
            $display("[TB] FAIL conv_oor_resp: got rvalid=%b data=%h want 1 0",
                     bus.conv_rvalid, bus.conv_rdata);
        end
        step();
    endtask

    task automatic test_swap();
        bus.conv_req = 1'b1; bus.conv_we = 1'b1; bus.conv_addr = 17'd10; bus.conv_wdata = 4'h3;
        step();
        clear_inputs();
        vectors++;
        if (bus.mem_addr !== 18'd76810 || bus.mem_we !== 1'b1 || bus.mem_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conv_write: got en=%b we=%b addr=%0d want 1 1 76810",
                     bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        step();
        bus.conv_frame_done = 1'b1;
        step();
        bus.conv_frame_done = 1'b0;
        vectors++;
        if (bus.swap_pending !== 1'b1 || bus.frame_swapped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_pending: got pend=%b swapped=%b want 1 0",
                     bus.swap_pending, bus.frame_swapped);
        end
        bus.vga_frame_start = 1'b1;
        step();
        bus.vga_frame_start = 1'b0;
        vectors++;
        if (bus.frame_swapped !== 1'b1 || bus.front_bank !== 1'b1 || bus.swap_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_apply: got swapped=%b bank=%b pend=%b want 1 1 0",
                     bus.frame_swapped, bus.front_bank, bus.swap_pending);
        end
        step();
        vectors++;
        if (bus.frame_swapped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_pulse: got %b want 0", bus.frame_swapped);
        end
        bus.vga_req = 1'b1; bus.vga_x = 10'd10; bus.vga_y = 10'd0;
        step();
        bus.vga_req = 1'b0;
        step();
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b1 || bus.vga_pixel !== 4'h3) begin
            errors++;
            $display("[TB] FAIL swap_vga_read: got valid=%b pix=%h want 1 3",
                     bus.vga_pixel_valid, bus.vga_pixel);
        end
        step();
    endtask

    task automatic test_stall();
        bus.conv_frame_done = 1'b1;
        step();
        bus.conv_frame_done = 1'b0;
        bus.conv_req = 1'b1; bus.conv_we = 1'b0; bus.conv_addr = 17'd3;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (bus.conv_gnt !== 1'b0 || bus.swap_pending !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_cycle%0d: got gnt=%b pend=%b want 0 1",
                         i, bus.conv_gnt, bus.swap_pending);
            end
        end
        bus.vga_frame_start = 1'b1;
        step();
        bus.vga_frame_start = 1'b0;
        vectors++;
        if (bus.conv_gnt !== 1'b1 || bus.front_bank !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: got gnt=%b bank=%b want 1 0",
                     bus.conv_gnt, bus.front_bank);
        end
        step();
        bus.conv_req = 1'b0;
        step();
        step();
        vectors++;
        if (bus.conv_rvalid !== 1'b1 || bus.conv_rdata !== 4'h5) begin
            errors++;
            $display("[TB] FAIL stall_read: got rvalid=%b data=%h want 1 5",
                     bus.conv_rvalid, bus.conv_rdata);
        end
`ifdef STARVE_STAT_EN
        vectors++;
        if (bus.conv_max_wait < 16'd20) begin
            errors++;
            $display("[TB] FAIL max_wait: got %0d want >=20", bus.conv_max_wait);
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        ram[321] = 4'h2;
        ram[322] = 4'h4;
        ram[323] = 4'h6;
        bus.vga_req = 1'b1; bus.vga_y = 10'd1; bus.vga_x = 10'd1;
        step();
        bus.vga_x = 10'd2;
        step();
        bus.vga_x = 10'd3;
        step();
        bus.vga_req = 1'b0;
        vectors++;
        if (bus.vga_pixel_valid !== 1'b1 || bus.vga_pixel !== 4'h2) begin
            errors++;
            $display("[TB] FAIL b2b_0: got valid=%b pix=%h want 1 2", bus.vga_pixel_valid, bus.vga_pixel);
        end
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b1 || bus.vga_pixel !== 4'h4) begin
            errors++;
            $display("[TB] FAIL b2b_1: got valid=%b pix=%h want 1 4", bus.vga_pixel_valid, bus.vga_pixel);
        end
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b1 || bus.vga_pixel !== 4'h6) begin
            errors++;
            $display("[TB] FAIL b2b_2: got valid=%b pix=%h want 1 6", bus.vga_pixel_valid, bus.vga_pixel);
        end
        step();
        vectors++;
        if (bus.vga_pixel_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got %b want 0", bus.vga_pixel_valid);
        end
    endtask

    task automatic test_reset_inflight();
        bus.conv_frame_done = 1'b1;
        bus.vga_frame_start = 1'b1;
        step();
        bus.conv_frame_done = 1'b0;
        bus.vga_frame_start = 1'b0;
        vectors++;
        if (bus.frame_swapped !== 1'b1 || bus.front_bank !== 1'b1 || bus.swap_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_immediate: got swapped=%b bank=%b pend=%b want 1 1 0",
                     bus.frame_swapped, bus.front_bank, bus.swap_pending);
        end
        bus.vga_req = 1'b1; bus.vga_x = 10'd1; bus.vga_y = 10'd1;
        step();
        bus.vga_x = 10'd2;
        step();
        bus.vga_req = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.vga_pixel, bus.vga_pixel_valid, bus.display_image, bus.conv_rvalid,
             bus.conv_rdata, bus.swap_pending, bus.frame_swapped, bus.mem_en,
             bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.front_bank} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs: some output nonzero, expected all 0");
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus.vga_pixel_valid !== 1'b0 || bus.front_bank !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset%0d: got valid=%b bank=%b want 0 0",
                         i, bus.vga_pixel_valid, bus.front_bank);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_vga_in_range();
        test_vga_out_of_range();
        test_arbitration();
        test_conv_out_of_range();
        test_swap();
        test_stall();
        test_back_to_back();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
